// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the RTC bus master and the sequencer above it.
//   - FSM state codes (4-bit, sequential so the phase states advance by +1)
//   - default bus width and phase length
//   - RTC register addresses (seconds..year, control)
package rtc_pkg;

   localparam int RTC_DW      = 8;
   localparam int T_PHASE_DEF = 2;

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_A_SETUP  = 4'd1;
   localparam logic [3:0] S_A_STROBE = 4'd2;
   localparam logic [3:0] S_A_HOLD   = 4'd3;
   localparam logic [3:0] S_TURN     = 4'd4;
   localparam logic [3:0] S_D_SETUP  = 4'd5;
   localparam logic [3:0] S_D_STROBE = 4'd6;
   localparam logic [3:0] S_D_HOLD   = 4'd7;
   localparam logic [3:0] S_DONE     = 4'd8;

   localparam logic [7:0] REG_SEC   = 8'h00;
   localparam logic [7:0] REG_MIN   = 8'h02;
   localparam logic [7:0] REG_HOUR  = 8'h04;
   localparam logic [7:0] REG_DOW   = 8'h06;
   localparam logic [7:0] REG_DATE  = 8'h07;
   localparam logic [7:0] REG_MONTH = 8'h08;
   localparam logic [7:0] REG_YEAR  = 8'h09;
   localparam logic [7:0] REG_CTRL  = 8'h0B;

endpackage

// File: rtl/phase_timer.sv
// phase_timer: 8-bit down-counter that measures one bus phase.
//   clk   in  system clock
//   rst   in  synchronous reset, active-high
//   load  in  reload the counter with LOAD (T_PHASE-1)
//   last  out high while the counter is at zero (final cycle of the phase)
module phase_timer #(
   parameter logic [7:0] LOAD = 8'd1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic last
);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || load)
         cnt <= LOAD;
      else if (cnt != 8'd0)
         cnt <= cnt - 8'd1;
   end

   assign last = (cnt == 8'd0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: bus master for the RTC multiplexed address/data port.
// One read or write per start: address phase, turnaround, data phase, done.
//   clk, rst            clock, synchronous active-high reset
//   start, wr           request and direction (1 = write), sampled in IDLE
//   addr, wdata         register address / write byte, latched with start
//   ad_in               AD bus from the pads
//   ad_out, ad_oe       AD bus drive value and enable (tristate built above)
//   cs_n, rd_n, wr_n    chip select and strobes, active low
//   ad_n                0 = address cycle, 1 = data cycle
//   rdata               last read byte, stable between dones
//   busy, done          not-IDLE flag, one-cycle completion pulse
module rtc_bus_ctrl
   import rtc_pkg::*;
#(
   parameter int T_PHASE = T_PHASE_DEF,
   parameter int DW      = RTC_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          wr,
   input  logic [DW-1:0] addr,
   input  logic [DW-1:0] wdata,
   input  logic [DW-1:0] ad_in,
   output logic [DW-1:0] ad_out,
   output logic          ad_oe,
   output logic          cs_n,
   output logic          rd_n,
   output logic          wr_n,
   output logic          ad_n,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          done
);

   logic [3:0]    state, state_nx;
   logic          last, load;
   logic          wr_q;
   logic [DW-1:0] addr_q, wdata_q;

   // On the accepting edge the latches are not yet loaded, so the first
   // registered address cycle must see the live inputs.
   logic          wr_eff;
   logic [DW-1:0] addr_eff, wdata_eff;
   assign wr_eff    = (state == S_IDLE) ? wr    : wr_q;
   assign addr_eff  = (state == S_IDLE) ? addr  : addr_q;
   assign wdata_eff = (state == S_IDLE) ? wdata : wdata_q;

   // Counter restarts on every state change and is parked while idle.
   assign load = (state_nx != state) || (state == S_IDLE);

   phase_timer #(.LOAD(8'(T_PHASE - 1))) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .last (last)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:     if (start) state_nx = S_A_SETUP;
         S_A_SETUP, S_A_STROBE, S_A_HOLD, S_TURN,
         S_D_SETUP, S_D_STROBE, S_D_HOLD:
                     if (last) state_nx = state + 4'd1;
         default:    state_nx = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered below, so the
   // pins line up with the state they belong to.
   logic          cs_nx, rd_nx, wr_nx, adn_nx, oe_nx;
   logic [DW-1:0] out_nx;

   always_comb begin
      cs_nx  = 1'b1;
      rd_nx  = 1'b1;
      wr_nx  = 1'b1;
      adn_nx = 1'b1;
      oe_nx  = 1'b0;
      out_nx = '0;
      case (state_nx)
         S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
            cs_nx  = 1'b0;
            adn_nx = 1'b0;
            oe_nx  = 1'b1;
            out_nx = addr_eff;
            wr_nx  = (state_nx != S_A_STROBE);
         end
         S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
            cs_nx = 1'b0;
            if (wr_eff) begin
               oe_nx  = 1'b1;
               out_nx = wdata_eff;
               wr_nx  = (state_nx != S_D_STROBE);
            end else begin
               rd_nx  = (state_nx != S_D_STROBE);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_n    <= 1'b1;
         rd_n    <= 1'b1;
         wr_n    <= 1'b1;
         ad_n    <= 1'b1;
         ad_oe   <= 1'b0;
         ad_out  <= '0;
         rdata   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         cs_n   <= cs_nx;
         rd_n   <= rd_nx;
         wr_n   <= wr_nx;
         ad_n   <= adn_nx;
         ad_oe  <= oe_nx;
         ad_out <= out_nx;
         busy   <= (state_nx != S_IDLE);
         done   <= (state_nx == S_DONE);
         if (state == S_IDLE && start) begin
            wr_q    <= wr;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         // Sample the pads at the end of the read strobe.
         if (state == S_D_STROBE && last && !wr_q)
            rdata <= ad_in;
      end
   end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: directed bench for rtc_bus_ctrl. dut runs T_PHASE=2,
// dut1 runs T_PHASE=1 for the back-to-back throughput test.
module tb_rtc_bus_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, wr, start1;
   logic [7:0] addr, wdata, ad_in;
   logic [7:0] ad_out, rdata, ad_out1, rdata1;
   logic       ad_oe, cs_n, rd_n, wr_n, ad_n, busy, done;
   logic       ad_oe1, cs_n1, rd_n1, wr_n1, ad_n1, busy1, done1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rtc_bus_ctrl #(.T_PHASE(2), .DW(8)) dut (
      .clk(clk), .rst(rst), .start(start), .wr(wr), .addr(addr), .wdata(wdata),
      .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n),
      .wr_n(wr_n), .ad_n(ad_n), .rdata(rdata), .busy(busy), .done(done)
   );

   rtc_bus_ctrl #(.T_PHASE(1), .DW(8)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .wr(1'b0), .addr(8'h09), .wdata(8'h00),
      .ad_in(8'h11), .ad_out(ad_out1), .ad_oe(ad_oe1), .cs_n(cs_n1), .rd_n(rd_n1),
      .wr_n(wr_n1), .ad_n(ad_n1), .rdata(rdata1), .busy(busy1), .done(done1)
   );

   // {cs_n, rd_n, wr_n, ad_n, ad_oe, busy, done, ad_out}
   logic [14:0] obs;
   assign obs = {cs_n, rd_n, wr_n, ad_n, ad_oe, busy, done, ad_out};

   // Expected pins per phase: A_SETUP..D_HOLD, DONE, IDLE
   logic [14:0] wr_tab [0:8];
   logic [14:0] rd_tab [0:8];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycle 1..14 -> phase (c-1)/2, cycle 15 -> DONE, 16 -> IDLE
   function automatic int ph(input int c);
      return (c <= 14) ? (c - 1) / 2 : c - 8;
   endfunction

   initial begin
      int ndone, last_done;

      wr_tab[0] = {7'b0110110, 8'h21};
      wr_tab[1] = {7'b0100110, 8'h21};
      wr_tab[2] = {7'b0110110, 8'h21};
      wr_tab[3] = {7'b1111010, 8'h00};
      wr_tab[4] = {7'b0111110, 8'h45};
      wr_tab[5] = {7'b0101110, 8'h45};
      wr_tab[6] = {7'b0111110, 8'h45};
      wr_tab[7] = {7'b1111011, 8'h00};
      wr_tab[8] = {7'b1111000, 8'h00};
      rd_tab[0] = {7'b0110110, 8'h22};
      rd_tab[1] = {7'b0100110, 8'h22};
      rd_tab[2] = {7'b0110110, 8'h22};
      rd_tab[3] = {7'b1111010, 8'h00};
      rd_tab[4] = {7'b0111010, 8'h00};
      rd_tab[5] = {7'b0011010, 8'h00};
      rd_tab[6] = {7'b0111010, 8'h00};
      rd_tab[7] = {7'b1111011, 8'h00};
      rd_tab[8] = {7'b1111000, 8'h00};

      // 1: reset with random inputs
      rst = 1'b1; start1 = 1'b0;
      repeat (3) begin
         start = 1'($urandom); wr = 1'($urandom);
         addr = 8'($urandom); wdata = 8'($urandom); ad_in = 8'($urandom);
         tick();
      end
      chk("rst_pins", 32'(obs), 32'({7'b1111000, 8'h00}));
      chk("rst_rdata", 32'(rdata), 32'h00);
      chk("rst_pins_t1", 32'({cs_n1, rd_n1, wr_n1, ad_n1, ad_oe1, busy1, done1, ad_out1}),
          32'({7'b1111000, 8'h00}));
      rst = 1'b0; start = 1'b0; ad_in = 8'hEE;
      tick();

      // 2: write 21 <- 45
      start = 1'b1; wr = 1'b1; addr = 8'h21; wdata = 8'h45;
      tick();
      start = 1'b0; addr = 8'h00; wdata = 8'h00;
      for (int c = 1; c <= 16; c++) begin
         chk($sformatf("wr_c%0d", c), 32'(obs), 32'(wr_tab[ph(c)]));
         tick();
      end
      chk("wr_rdata", 32'(rdata), 32'h00);

      // 3: read 22, pads drive 37 only during D_STROBE
      start = 1'b1; wr = 1'b0; addr = 8'h22;
      tick();
      start = 1'b0; addr = 8'h00;
      for (int c = 1; c <= 16; c++) begin
         ad_in = (c == 11 || c == 12) ? 8'h37 : 8'hEE;
         chk($sformatf("rd_c%0d", c), 32'(obs), 32'(rd_tab[ph(c)]));
         if (c == 12) chk("rd_rdata_pre", 32'(rdata), 32'h00);
         if (c == 15) chk("rd_rdata_done", 32'(rdata), 32'h37);
         tick();
      end

      // 4: start re-pulsed while busy
      start = 1'b1; wr = 1'b0; addr = 8'h07; ad_in = 8'h5A;
      tick();
      ndone = 0;
      for (int c = 1; c <= 24; c++) begin
         start = (c == 3 || c == 9);
         if (done) begin
            ndone++;
            chk("ign_done_cyc", 32'(c), 32'd15);
         end
         tick();
      end
      start = 1'b0;
      chk("ign_ndone", 32'(ndone), 32'd1);
      chk("ign_rdata", 32'(rdata), 32'h5A);

      // 5: reset during D_STROBE of a read
      start = 1'b1; wr = 1'b0; addr = 8'h08; ad_in = 8'h99;
      tick();
      start = 1'b0;
      repeat (10) tick();
      chk("abort_in_strobe", 32'({cs_n, rd_n}), 32'b00);
      chk("abort_rdata_pre", 32'(rdata), 32'h5A);
      rst = 1'b1;
      tick();
      chk("abort_pins", 32'({cs_n, rd_n, ad_oe, busy, done}), 32'b11000);
      chk("abort_rdata", 32'(rdata), 32'h00);
      rst = 1'b0;
      tick();
      chk("abort_idle", 32'({busy, done}), 32'b00);

      // 6: T_PHASE=1, start held high
      start1 = 1'b1;
      ndone = 0; last_done = -1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (done1) begin
            ndone++;
            if (last_done < 0) chk("tp1_first", 32'(c), 32'd8);
            else               chk("tp1_period", 32'(c - last_done), 32'd9);
            last_done = c;
         end
         chk($sformatf("tp1_strobe_c%0d", c),
             32'({!rd_n1 && !wr_n1, (!rd_n1 || !wr_n1) && cs_n1}), 32'b00);
      end
      start1 = 1'b0;
      chk("tp1_ndone", 32'(ndone), 32'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
